// File: rtl/snake_board_writer_if.sv
// snake_board_writer_if
// Bundles the game-control inputs and the board BMEM port of the snake
// board writer.
//   restart, step, dir, grow : control from game-tick/input logic
//   addr, we, wdata, re      : BMEM address/strobe/data from the writer
//   rdata                    : BMEM read data, valid the cycle after re
//   busy, game_over, length  : status back to the game logic
// Modports: slave = the writer, master = its environment (control + BMEM).
interface snake_board_writer_if;
    logic       restart;
    logic       step;
    logic [1:0] dir;
    logic       grow;
    logic [9:0] addr;
    logic       we;
    logic [1:0] wdata;
    logic       re;
    logic [1:0] rdata;
    logic       busy;
    logic       game_over;
    logic [6:0] length;

    modport slave (
        input  restart, step, dir, grow, rdata,
        output addr, we, wdata, re, busy, game_over, length
    );

    modport master (
        output restart, step, dir, grow, rdata,
        input  addr, we, wdata, re, busy, game_over, length
    );
endinterface

// File: rtl/snake_board_writer.sv
// snake_board_writer
// Writer side of the 1k-cell board memory scanned by the VGA path. Keeps
// the snake body as a circular buffer of cell addresses and, per game step,
// probes the new head cell, writes the head and erases the tail.
// Address format: addr[4:0] = column 0..31, addr[9:5] = row 0..23.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : snake_board_writer_if.slave (control, BMEM port, status)
//
// state   | meaning
// --------+-------------------------------------------------------
// S_CLEAR | write 0 to cells 0..767, one per cycle
// S_INIT  | write the initial snake, tail first, fill body buffer
// S_IDLE  | wait for step, compute new head, bounds check
// S_READ  | read the new head cell
// S_CHECK | collision test on rdata
// S_WHEAD | write the new head, push it into the body buffer
// S_ETAIL | erase the tail cell, pop it from the body buffer
// S_DEAD  | game over, wait for restart
module snake_board_writer #(
    parameter int MAXLEN   = 64,
    parameter int INIT_LEN = 4,
    parameter int INIT_ROW = 12,
    parameter int INIT_COL = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    snake_board_writer_if.slave  bus
);
    localparam int          PW        = $clog2(MAXLEN);
    localparam logic [9:0]  CLR_LAST  = 10'd767;
    localparam logic [9:0]  INIT_LAST = 10'(INIT_LEN - 1);
    localparam logic [9:0]  INIT_BASE = 10'(INIT_ROW * 32 + INIT_COL);
    localparam logic [6:0]  MAXLEN_L  = 7'(MAXLEN);

    typedef enum logic [2:0] {
        S_CLEAR, S_INIT, S_IDLE, S_READ, S_CHECK, S_WHEAD, S_ETAIL, S_DEAD
    } state_t;

    state_t          state, state_d;
    logic [9:0]      cnt;
    logic [1:0]      cur_dir;
    logic            grow_q;
    logic [9:0]      nhead;
    logic [9:0]      tail_q;
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic [6:0]      length;
    logic [9:0]      body [MAXLEN];

    logic [PW-1:0]   last_ptr;
    logic [9:0]      head;
    logic [1:0]      eff_dir;
    logic signed [5:0] hrow, hcol, nrow, ncol;
    logic            oob;
    logic [9:0]      nhead_c;
    logic            grow_ok;

    assign last_ptr = head_ptr - PW'(1);
    assign head     = body[last_ptr];
    // A request for the exact opposite direction would fold the snake onto
    // its own neck, so it is treated as "keep going".
    assign eff_dir  = (bus.dir == (cur_dir ^ 2'b10)) ? cur_dir : bus.dir;
    assign hrow     = $signed({1'b0, head[9:5]});
    assign hcol     = $signed({1'b0, head[4:0]});
    assign grow_ok  = grow_q && (length < MAXLEN_L);

    always_comb begin
        nrow = hrow;
        ncol = hcol;
        case (eff_dir)
            2'd0:    ncol = hcol + 6'sd1;
            2'd1:    nrow = hrow + 6'sd1;
            2'd2:    ncol = hcol - 6'sd1;
            default: nrow = hrow - 6'sd1;
        endcase
    end

    assign oob     = (ncol < 6'sd0) || (ncol > 6'sd31) ||
                     (nrow < 6'sd0) || (nrow > 6'sd23);
    assign nhead_c = {nrow[4:0], ncol[4:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_CLEAR;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_CLEAR: if (cnt == CLR_LAST) state_d = S_INIT;
            S_INIT:  if (cnt == INIT_LAST) state_d = S_IDLE;
            S_IDLE:  if (bus.step) state_d = oob ? S_DEAD : S_READ;
            S_READ:  state_d = S_CHECK;
            S_CHECK: state_d = (bus.rdata == 2'd1) ? S_DEAD : S_WHEAD;
            S_WHEAD: state_d = grow_ok ? S_IDLE : S_ETAIL;
            S_ETAIL: state_d = S_IDLE;
            default: state_d = state;
        endcase
        if (bus.restart) state_d = S_CLEAR;
    end

    always_comb begin
        bus.addr  = 10'd0;
        bus.we    = 1'b0;
        bus.wdata = 2'd0;
        bus.re    = 1'b0;
        case (state)
            S_CLEAR: begin
                bus.we   = 1'b1;
                bus.addr = cnt;
            end
            S_INIT: begin
                bus.we    = 1'b1;
                bus.addr  = INIT_BASE + cnt;
                bus.wdata = 2'd1;
            end
            S_READ: begin
                bus.re   = 1'b1;
                bus.addr = nhead;
            end
            S_WHEAD: begin
                bus.we    = 1'b1;
                bus.addr  = nhead;
                bus.wdata = 2'd1;
            end
            S_ETAIL: begin
                bus.we   = 1'b1;
                bus.addr = tail_q;
            end
            default: ;
        endcase
        // The state register sits in CLEAR while reset is held; keep the
        // memory quiet until reset is released.
        if (reset) bus.we = 1'b0;
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.game_over = (state == S_DEAD);
    assign bus.length    = length;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            cur_dir  <= 2'd0;
            grow_q   <= 1'b0;
            nhead    <= '0;
            tail_q   <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            length   <= '0;
        end else if (bus.restart) begin
            cnt <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    cnt      <= (cnt == CLR_LAST) ? 10'd0 : cnt + 10'd1;
                    head_ptr <= '0;
                    tail_ptr <= '0;
                    length   <= '0;
                end
                S_INIT: begin
                    cnt      <= (cnt == INIT_LAST) ? 10'd0 : cnt + 10'd1;
                    head_ptr <= head_ptr + PW'(1);
                    length   <= length + 7'd1;
                    cur_dir  <= 2'd0;
                end
                S_IDLE: if (bus.step) begin
                    cur_dir <= eff_dir;
                    grow_q  <= bus.grow;
                    nhead   <= nhead_c;
                end
                S_WHEAD: begin
                    head_ptr <= head_ptr + PW'(1);
                    // With a full buffer the head push lands on the tail
                    // slot, so the tail address is saved first.
                    tail_q   <= body[tail_ptr];
                    if (grow_ok) length <= length + 7'd1;
                end
                S_ETAIL: tail_ptr <= tail_ptr + PW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT)       body[head_ptr] <= INIT_BASE + cnt;
        else if (state == S_WHEAD) body[head_ptr] <= nhead;
    end
endmodule

// File: tb/tb_snake_board_writer.sv
// tb_snake_board_writer
// Drives snake_board_writer through reset, moves, growth, direction
// reversal, buffer-full growth, wall and body collisions and restarts.
// A board memory model answers reads; every memory access the writer makes
// is checked in order against a queue of expected accesses.
module tb_snake_board_writer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    snake_board_writer_if bus();

    snake_board_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit wr;
        int a;
        int d;
    } op_t;

    op_t  exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [1:0] board [1024];
    bit         obst  [1024];

    int   body_q[$];
    int   mdir  = 0;
    int   mh    = 0;
    bit   mdead = 0;

    always @(posedge clk) begin
        if (bus.re) bus.rdata <= obst[bus.addr] ? 2'd1 : board[bus.addr];
        if (bus.we) board[bus.addr] <= bus.wdata;
    end

    op_t mon_e;
    always @(negedge clk) begin
        if (!reset && (bus.we === 1'b1 || bus.re === 1'b1)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL op_unexpected: got we=%0b re=%0b addr=%0d wdata=%0d, required no access",
                         bus.we, bus.re, bus.addr, bus.wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.we !== mon_e.wr || bus.re !== !mon_e.wr || bus.addr !== 10'(mon_e.a) ||
                    (mon_e.wr && bus.wdata !== 2'(mon_e.d)))
                    $display("FAIL op_match: got we=%0b re=%0b addr=%0d wdata=%0d, required %s addr=%0d data=%0d",
                             bus.we, bus.re, bus.addr, bus.wdata, mon_e.wr ? "write" : "read", mon_e.a, mon_e.d);
                else
                    n_pass++;
            end
        end
    end

    task automatic push_op(input bit wr, input int a, input int d);
        op_t o;
        o.wr = wr; o.a = a; o.d = d;
        exp_q.push_back(o);
    endtask

    task automatic push_clear(input int last);
        for (int i = 0; i <= last; i++) push_op(1, i, 0);
    endtask

    task automatic push_init();
        body_q.delete();
        for (int i = 0; i < 4; i++) begin
            push_op(1, 12 * 32 + 8 + i, 1);
            body_q.push_back(12 * 32 + 8 + i);
        end
        mdir = 0; mh = 0; mdead = 0;
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.busy === 1'b0) break;
        end
    endtask

    task automatic check_settled(input string name, input int cyc, input int want_cyc);
        n_chk++;
        if (cyc !== want_cyc) $display("FAIL %s_cycles: got %0d, required %0d", name, cyc, want_cyc);
        else n_pass++;
        n_chk++;
        if (bus.length !== 7'(body_q.size()))
            $display("FAIL %s_length: got %0d, required %0d", name, bus.length, body_q.size());
        else n_pass++;
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL %s_pending_ops: got %0d left, required 0", name, exp_q.size());
        else n_pass++;
        n_chk++;
        if (bus.game_over !== 1'b0) $display("FAIL %s_game_over: got %0b, required 0", name, bus.game_over);
        else n_pass++;
    endtask

    // One game step from IDLE; hold > 0 keeps step asserted (with a
    // different dir and grow) for that many busy cycles.
    task automatic do_step(input int d, input bit g, input int hold);
        int  eff, head, r, c, nh, cyc, tmp;
        bit  oob, hit, grows;
        eff  = (d == (mdir ^ 2)) ? mdir : d;
        head = body_q[body_q.size() - 1];
        r = head / 32;
        c = head % 32;
        case (eff)
            0: c++;
            1: r++;
            2: c--;
            default: r--;
        endcase
        oob = (c < 0) || (c > 31) || (r < 0) || (r > 23);
        nh  = r * 32 + c;
        hit = 0;
        if (!oob) begin
            if (obst[nh]) hit = 1;
            foreach (body_q[i]) if (body_q[i] == nh) hit = 1;
            push_op(0, nh, 0);
        end
        mdir  = eff;
        grows = g && (body_q.size() < 64);
        if (!oob && !hit) begin
            push_op(1, nh, 1);
            if (!grows) begin
                push_op(1, body_q[0], 0);
                tmp = body_q.pop_front();
            end
            body_q.push_back(nh);
        end

        bus.dir = 2'(d); bus.grow = g; bus.step = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < hold; k++) begin
            bus.dir = 2'd1; bus.grow = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        bus.step = 1'b0; bus.grow = 1'b0;

        if (oob || hit) begin
            mdead = 1;
            repeat (3) @(negedge clk);
            n_chk++;
            if (bus.game_over !== 1'b1) $display("FAIL step_dead_game_over: got %0b, required 1", bus.game_over);
            else n_pass++;
            n_chk++;
            if (exp_q.size() != 0) $display("FAIL step_dead_pending_ops: got %0d left, required 0", exp_q.size());
            else n_pass++;
        end else begin
            wait_idle(12, cyc);
            check_settled("step", 1 + hold + cyc, grows ? 4 : 5);
        end
    endtask

    function automatic int next_dir();
        int head, c;
        head = body_q[body_q.size() - 1];
        c = head % 32;
        if (mdir == 1) begin
            mh = (mh == 0) ? 2 : 0;
            return mh;
        end
        if ((mdir == 0 && c == 30) || (mdir == 2 && c == 1)) return 1;
        return mdir;
    endfunction

    task automatic test_reset();
        int cyc;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (bus.we !== 1'b0) $display("FAIL reset_we: got %0b, required 0", bus.we); else n_pass++;
        n_chk++; if (bus.re !== 1'b0) $display("FAIL reset_re: got %0b, required 0", bus.re); else n_pass++;
        n_chk++; if (bus.addr !== 10'd0) $display("FAIL reset_addr: got %0d, required 0", bus.addr); else n_pass++;
        n_chk++; if (bus.wdata !== 2'd0) $display("FAIL reset_wdata: got %0d, required 0", bus.wdata); else n_pass++;
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %0b, required 1", bus.busy); else n_pass++;
        n_chk++; if (bus.game_over !== 1'b0) $display("FAIL reset_game_over: got %0b, required 0", bus.game_over); else n_pass++;
        n_chk++; if (bus.length !== 7'd0) $display("FAIL reset_length: got %0d, required 0", bus.length); else n_pass++;
        push_clear(767);
        push_init();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        wait_idle(900, cyc);
        check_settled("reset_release", cyc, 772);
    endtask

    task automatic test_restart();
        int cyc;
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL restart_pending_ops: got %0d left, required 0", exp_q.size());
        else n_pass++;
        push_clear(767);
        push_init();
        bus.restart = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.restart = 1'b0;
        wait_idle(900, cyc);
        check_settled("restart", cyc, 772);
    endtask

    task automatic test_move();
        do_step(0, 0, 0);
    endtask

    task automatic test_grow();
        do_step(0, 1, 0);
    endtask

    task automatic test_reversal_drop();
        do_step(2, 0, 2);
    endtask

    task automatic test_max_len();
        int guard = 0;
        while (body_q.size() < 64 && guard < 100) begin
            do_step(next_dir(), 1, 0);
            guard++;
        end
        do_step(next_dir(), 1, 0);
        do_step(next_dir(), 0, 0);
    endtask

    task automatic test_wall(input int d);
        int guard = 0;
        while (!mdead && guard < 40) begin
            do_step(d, 0, 0);
            guard++;
        end
        n_chk++;
        if (bus.game_over !== 1'b1) $display("FAIL wall_reached: got game_over=%0b, required 1", bus.game_over);
        else n_pass++;
    endtask

    task automatic test_dead_ignores_step();
        for (int i = 0; i < 3; i++) begin
            bus.step = 1'b1; bus.dir = 2'd1; bus.grow = 1'b1;
            @(negedge clk);
            bus.step = 1'b0; bus.grow = 1'b0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.game_over !== 1'b1) $display("FAIL dead_step_game_over: got %0b, required 1", bus.game_over);
        else n_pass++;
        n_chk++;
        if (bus.busy !== 1'b1) $display("FAIL dead_step_busy: got %0b, required 1", bus.busy);
        else n_pass++;
        n_chk++;
        if (bus.length !== 7'(body_q.size()))
            $display("FAIL dead_step_length: got %0d, required %0d", bus.length, body_q.size());
        else n_pass++;
    endtask

    task automatic test_collision();
        obst[396] = 1'b1;
        do_step(0, 0, 0);
        obst[396] = 1'b0;
    endtask

    task automatic test_restart_mid_clear();
        int cyc;
        push_clear(300);
        bus.restart = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.restart = 1'b0;
        repeat (300) @(negedge clk);
        push_clear(767);
        push_init();
        bus.restart = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.restart = 1'b0;
        n_chk++;
        if (bus.addr !== 10'd0 || bus.we !== 1'b1)
            $display("FAIL mid_clear_restart_addr: got addr=%0d we=%0b, required addr=0 we=1", bus.addr, bus.we);
        else n_pass++;
        wait_idle(900, cyc);
        check_settled("mid_clear", cyc, 772);
    endtask

    initial begin
        bus.restart = 1'b0;
        bus.step    = 1'b0;
        bus.dir     = 2'd0;
        bus.grow    = 1'b0;
        for (int i = 0; i < 1024; i++) obst[i] = 1'b0;
        test_reset();
        test_move();
        test_grow();
        test_reversal_drop();
        test_max_len();
        test_restart();
        test_wall(0);
        test_dead_ignores_step();
        test_restart();
        test_wall(3);
        test_restart();
        test_collision();
        test_restart_mid_clear();
        test_move();
        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL final_pending_ops: got %0d left, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
